// File: rtl/shift_arbiter_if.sv
// ============================================================================
// shift_arbiter_if : bundle of the requester, shared-shifter and response
// signals of shift_arbiter. Rev 1.0
// ============================================================================
`default_nettype none

interface shift_arbiter_if;
  logic        Req0Valid;
  logic        Req1Valid;
  logic        Req0Ready;
  logic        Req1Ready;
  logic [1:0]  Req0Sh;
  logic [1:0]  Req1Sh;
  logic [4:0]  Req0Shamt5;
  logic [4:0]  Req1Shamt5;
  logic [31:0] Req0ShIn;
  logic [31:0] Req1ShIn;
  logic [1:0]  Sh;
  logic [4:0]  Shamt5;
  logic [31:0] ShIn;
  logic [31:0] ShOut;
  logic        RspValid;
  logic        RspId;
  logic [31:0] RspData;
  logic        RspReady;

  modport slave (
    input  Req0Valid, Req1Valid, Req0Sh, Req1Sh, Req0Shamt5, Req1Shamt5,
           Req0ShIn, Req1ShIn, ShOut, RspReady,
    output Req0Ready, Req1Ready, Sh, Shamt5, ShIn, RspValid, RspId, RspData
  );

  modport master (
    output Req0Valid, Req1Valid, Req0Sh, Req1Sh, Req0Shamt5, Req1Shamt5,
           Req0ShIn, Req1ShIn, ShOut, RspReady,
    input  Req0Ready, Req1Ready, Sh, Shamt5, ShIn, RspValid, RspId, RspData
  );
endinterface

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// shift_arbiter : two-requester round-robin front end for one shared
// combinational barrel shifter, with a single-entry response register.
// Optional macro SHIFT_ARB_BYPASS_EN : zero-amount shifts skip the SHIFT state.
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic           CLK,
  input  logic           RESETn,
  shift_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_run;
  logic        r_last;
  logic [1:0]  r_op_sh;
  logic [4:0]  r_op_shamt;
  logic [31:0] r_op_shin;
  logic        r_op_id;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_xfer;
  logic        w_sel_id;
  logic [1:0]  w_sel_sh;
  logic [4:0]  w_sel_shamt;
  logic [31:0] w_sel_shin;
  logic        w_bypass;

  // r_run holds grants off until the first edge after reset release;
  // on a tie the requester that was not served last wins.
  assign w_gnt0 = r_run && (r_state == S_IDLE) && bus.Req0Valid &&
                  (!bus.Req1Valid || r_last);
  assign w_gnt1 = r_run && (r_state == S_IDLE) && bus.Req1Valid &&
                  (!bus.Req0Valid || !r_last);
  assign w_xfer      = w_gnt0 || w_gnt1;
  assign w_sel_id    = w_gnt1;
  assign w_sel_sh    = w_gnt1 ? bus.Req1Sh     : bus.Req0Sh;
  assign w_sel_shamt = w_gnt1 ? bus.Req1Shamt5 : bus.Req0Shamt5;
  assign w_sel_shin  = w_gnt1 ? bus.Req1ShIn   : bus.Req0ShIn;

`ifdef SHIFT_ARB_BYPASS_EN
  assign w_bypass = (w_sel_shamt == 5'd0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_state_nxt = w_bypass ? S_RESP : S_SHIFT;
      S_SHIFT: w_state_nxt = S_RESP;
      S_RESP:  if (bus.RspReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Req0Ready = w_gnt0;
    bus.Req1Ready = w_gnt1;
    bus.Sh        = 2'b00;
    bus.Shamt5    = 5'd0;
    bus.ShIn      = 32'd0;
    bus.RspValid  = (r_state == S_RESP);
    bus.RspId     = r_rsp_id;
    bus.RspData   = r_rsp_data;
    if (r_state == S_SHIFT) begin
      bus.Sh     = r_op_sh;
      bus.Shamt5 = r_op_shamt;
      bus.ShIn   = r_op_shin;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_run      <= 1'b0;
      r_last     <= ~PRIO_INIT;
      r_op_sh    <= 2'b00;
      r_op_shamt <= 5'd0;
      r_op_shin  <= 32'd0;
      r_op_id    <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= 32'd0;
    end else begin
      r_run <= 1'b1;
      if (w_xfer) begin
        r_op_sh    <= w_sel_sh;
        r_op_shamt <= w_sel_shamt;
        r_op_shin  <= w_sel_shin;
        r_op_id    <= w_sel_id;
        r_last     <= w_sel_id;
        if (w_bypass) begin
          r_rsp_id   <= w_sel_id;
          r_rsp_data <= w_sel_shin;
        end
      end
      if (r_state == S_SHIFT) begin
        r_rsp_id   <= r_op_id;
        r_rsp_data <= bus.ShOut;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// tb_shift_arbiter : directed and randomized self-checking bench for
// shift_arbiter with a behavioural barrel shifter on the shared port. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shift_arbiter;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef SHIFT_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  shift_arbiter_if bus ();

  shift_arbiter #(.PRIO_INIT(1'b0)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // Shared barrel shifter seen by the arbiter
  logic [63:0] env_dbl;
  always_comb begin
    env_dbl = {bus.ShIn, bus.ShIn} >> bus.Shamt5;
    case (bus.Sh)
      2'b00:   bus.ShOut = bus.ShIn << bus.Shamt5;
      2'b01:   bus.ShOut = bus.ShIn >> bus.Shamt5;
      2'b10:   bus.ShOut = $unsigned($signed(bus.ShIn) >>> bus.Shamt5);
      default: bus.ShOut = env_dbl[31:0];
    endcase
  end

  // Reference: apply a one-bit step amt times
  function automatic logic [31:0] ref_shift(input logic [1:0] sh, input int amt,
                                            input logic [31:0] x);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < amt; i++) begin
      case (sh)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0;
    bus.Req0Sh = 2'b00; bus.Req1Sh = 2'b00;
    bus.Req0Shamt5 = 5'd0; bus.Req1Shamt5 = 5'd0;
    bus.Req0ShIn = 32'd0; bus.Req1ShIn = 32'd0;
    bus.RspReady = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.Req0Valid = 1'b1; bus.Req1Valid = 1'b1;
    bus.Req0Shamt5 = 5'd3; bus.Req1ShIn = 32'h1234;
    #3;
    n_checks++;
    if ({bus.Req1Ready, bus.Req0Ready} !== 2'b00)
      $display("FAIL reset_ready: got %b expected 00", {bus.Req1Ready, bus.Req0Ready});
    else n_pass++;
    n_checks++;
    if ({bus.RspValid, bus.RspId, bus.RspData} !== 34'd0)
      $display("FAIL reset_rsp: got v=%b id=%b d=%h expected 0", bus.RspValid, bus.RspId, bus.RspData);
    else n_pass++;
    n_checks++;
    if ({bus.Sh, bus.Shamt5, bus.ShIn} !== 39'd0)
      $display("FAIL reset_shdrive: got %h expected 0", {bus.Sh, bus.Shamt5, bus.ShIn});
    else n_pass++;
    @(posedge CLK);
    #1 RESETn = 1'b1;
    #1;
    n_checks++;
    if ({bus.Req1Ready, bus.Req0Ready} !== 2'b00)
      $display("FAIL release_ready: got %b expected 00", {bus.Req1Ready, bus.Req0Ready});
    else n_pass++;
    step();
    n_checks++;
    if ({bus.Req1Ready, bus.Req0Ready} !== 2'b01)
      $display("FAIL first_tie: got %b expected 01", {bus.Req1Ready, bus.Req0Ready});
    else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_ror();
    bus.Req0Sh = 2'b11; bus.Req0Shamt5 = 5'd4; bus.Req0ShIn = 32'h80000001;
    bus.Req0Valid = 1'b1; bus.RspReady = 1'b1;
    #1;
    n_checks++;
    if (bus.Req0Ready !== 1'b1) $display("FAIL ror_ready: got %b expected 1", bus.Req0Ready);
    else n_pass++;
    step();
    bus.Req0Valid = 1'b0;
    #1;
    n_checks++;
    if (bus.RspValid !== 1'b0) $display("FAIL ror_early_valid: got %b expected 0", bus.RspValid);
    else n_pass++;
    n_checks++;
    if ({bus.Sh, bus.Shamt5, bus.ShIn} !== {2'b11, 5'd4, 32'h80000001})
      $display("FAIL ror_shdrive: got %h expected %h", {bus.Sh, bus.Shamt5, bus.ShIn},
               {2'b11, 5'd4, 32'h80000001});
    else n_pass++;
    step();
    n_checks++;
    if ({bus.RspValid, bus.RspId, bus.RspData} !== {1'b1, 1'b0, 32'h18000000})
      $display("FAIL ror_rsp: got v=%b id=%b d=%h expected v=1 id=0 d=18000000",
               bus.RspValid, bus.RspId, bus.RspData);
    else n_pass++;
    n_checks++;
    if ({bus.Sh, bus.Shamt5, bus.ShIn} !== 39'd0)
      $display("FAIL resp_shdrive: got %h expected 0", {bus.Sh, bus.Shamt5, bus.ShIn});
    else n_pass++;
    step();
    n_checks++;
    if (bus.RspValid !== 1'b0) $display("FAIL ror_done: got %b expected 0", bus.RspValid);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [31:0] exp_d [2];
    int gi, ri, gprev;
    logic gid;
    exp_d[0] = ref_shift(2'b10, 31, 32'h80000000);
    exp_d[1] = ref_shift(2'b00, 31, 32'h00000001);
    gi = 0; ri = 0; gprev = 0;
    do_reset();
    bus.Req0Sh = 2'b10; bus.Req0Shamt5 = 5'd31; bus.Req0ShIn = 32'h80000000;
    bus.Req1Sh = 2'b00; bus.Req1Shamt5 = 5'd31; bus.Req1ShIn = 32'h00000001;
    bus.Req0Valid = 1'b1; bus.Req1Valid = 1'b1; bus.RspReady = 1'b1;
    for (int c = 0; c < 40 && (gi < 4 || ri < 4); c++) begin
      #1;
      if (gi < 4 && (bus.Req0Ready || bus.Req1Ready)) begin
        gid = bus.Req1Ready;
        n_checks++;
        if (gid !== gi[0]) $display("FAIL alt_grant%0d: got %b expected %b", gi, gid, gi[0]);
        else n_pass++;
        if (gi > 0) begin
          n_checks++;
          if (c - gprev != 3) $display("FAIL alt_spacing%0d: got %0d expected 3", gi, c - gprev);
          else n_pass++;
        end
        gprev = c;
        gi++;
      end
      if (bus.RspValid && bus.RspReady) begin
        n_checks++;
        if ({bus.RspId, bus.RspData} !== {ri[0], exp_d[ri % 2]})
          $display("FAIL alt_rsp%0d: got id=%b d=%h expected id=%b d=%h",
                   ri, bus.RspId, bus.RspData, ri[0], exp_d[ri % 2]);
        else n_pass++;
        ri++;
      end
      step();
      if (gi == 4) begin bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0; end
    end
    n_checks++;
    if (gi != 4 || ri != 4) $display("FAIL alt_timeout: got g=%0d r=%0d expected 4/4", gi, ri);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.Req1Sh = 2'b01; bus.Req1Shamt5 = 5'd4; bus.Req1ShIn = 32'hF0000000;
    bus.Req1Valid = 1'b1; bus.RspReady = 1'b0;
    #1;
    n_checks++;
    if (bus.Req1Ready !== 1'b1) $display("FAIL bp_ready: got %b expected 1", bus.Req1Ready);
    else n_pass++;
    step();
    bus.Req0Valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.Req1Ready, bus.Req0Ready} !== 2'b00)
      $display("FAIL bp_shift_ready: got %b expected 00", {bus.Req1Ready, bus.Req0Ready});
    else n_pass++;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.RspValid, bus.RspId, bus.RspData, bus.Req1Ready, bus.Req0Ready} !==
          {1'b1, 1'b1, 32'h0F000000, 2'b00})
        $display("FAIL bp_hold%0d: got v=%b id=%b d=%h rdy=%b%b expected v=1 id=1 d=0f000000 rdy=00",
                 i, bus.RspValid, bus.RspId, bus.RspData, bus.Req1Ready, bus.Req0Ready);
      else n_pass++;
      step();
    end
    bus.RspReady = 1'b1; bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0;
    #1;
    n_checks++;
    if (bus.RspValid !== 1'b1) $display("FAIL bp_final: got %b expected 1", bus.RspValid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.RspValid !== 1'b0) $display("FAIL bp_release: got %b expected 0", bus.RspValid);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int w, seen;
    idle_inputs();
    bus.Req0Sh = 2'b00; bus.Req0Shamt5 = 5'd8; bus.Req0ShIn = 32'h12345678;
    bus.Req0Valid = 1'b1;
    #1;
    n_checks++;
    if (bus.Req0Ready !== 1'b1) $display("FAIL rif_ready: got %b expected 1", bus.Req0Ready);
    else n_pass++;
    step();
    bus.Req0Valid = 1'b0;
    #1 RESETn = 1'b0;
    #1;
    n_checks++;
    if ({bus.RspValid, bus.Sh, bus.Shamt5, bus.ShIn} !== 40'd0)
      $display("FAIL rif_flush: got v=%b drive=%h expected 0", bus.RspValid,
               {bus.Sh, bus.Shamt5, bus.ShIn});
    else n_pass++;
    step();
    RESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.RspValid) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL rif_ghost: got %0d responses expected 0", seen);
    else n_pass++;
    bus.Req1Sh = 2'b11; bus.Req1Shamt5 = 5'd4; bus.Req1ShIn = 32'h000000F0;
    bus.Req1Valid = 1'b1;
    #1;
    w = 0;
    while (!bus.Req1Ready && w < 8) begin step(); w++; end
    n_checks++;
    if (bus.Req1Ready !== 1'b1) $display("FAIL rif_next_ready: got %b expected 1", bus.Req1Ready);
    else n_pass++;
    step();
    bus.Req1Valid = 1'b0;
    w = 0;
    while (!bus.RspValid && w < 8) begin step(); w++; end
    n_checks++;
    if ({bus.RspValid, bus.RspId, bus.RspData} !== {1'b1, 1'b1, 32'h0000000F})
      $display("FAIL rif_next_rsp: got v=%b id=%b d=%h expected v=1 id=1 d=0000000f",
               bus.RspValid, bus.RspId, bus.RspData);
    else n_pass++;
    step();
  endtask

  task automatic test_bypass();
    int w, lat;
    idle_inputs();
    bus.Req0Sh = 2'b00; bus.Req0Shamt5 = 5'd0; bus.Req0ShIn = 32'hDEADBEEF;
    bus.Req0Valid = 1'b1;
    #1;
    w = 0;
    while (!bus.Req0Ready && w < 8) begin step(); w++; end
    step();
    bus.Req0Valid = 1'b0;
    lat = 1;
    while (!bus.RspValid && lat < 6) begin step(); lat++; end
    n_checks++;
    if (lat != (BYP ? 1 : 2)) $display("FAIL bypass_latency: got %0d expected %0d", lat, BYP ? 1 : 2);
    else n_pass++;
    n_checks++;
    if ({bus.RspValid, bus.RspId, bus.RspData} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL bypass_rsp: got v=%b id=%b d=%h expected v=1 id=0 d=deadbeef",
               bus.RspValid, bus.RspId, bus.RspData);
    else n_pass++;
    step();
  endtask

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic m_last;
    logic exp_any, exp_id, exp_rv;
    logic [1:0] exp_rdy;
    do_reset();
    m_last = 1'b1;
    for (int c = 0; c < 300; c++) begin
      bus.Req0Valid  = ($urandom_range(0, 2) != 0);
      bus.Req1Valid  = ($urandom_range(0, 2) != 0);
      bus.Req0Sh     = 2'($urandom);
      bus.Req1Sh     = 2'($urandom);
      bus.Req0Shamt5 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.Req1Shamt5 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.Req0ShIn   = $urandom;
      bus.Req1ShIn   = $urandom;
      bus.RspReady   = ($urandom_range(0, 1) != 0);
      #1;
      exp_any = (q.size() == 0) && (bus.Req0Valid || bus.Req1Valid);
      exp_id  = (bus.Req0Valid && bus.Req1Valid) ? !m_last : bus.Req1Valid;
      exp_rdy = exp_any ? (exp_id ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if ({bus.Req1Ready, bus.Req0Ready} !== exp_rdy)
        $display("FAIL rnd_ready c%0d: got %b expected %b", c, {bus.Req1Ready, bus.Req0Ready}, exp_rdy);
      else n_pass++;
      exp_rv = (q.size() > 0) && (c >= q[0].due);
      n_checks++;
      if (bus.RspValid !== exp_rv)
        $display("FAIL rnd_rspvalid c%0d: got %b expected %b", c, bus.RspValid, exp_rv);
      else n_pass++;
      if (exp_rv) begin
        n_checks++;
        if ({bus.RspId, bus.RspData} !== {q[0].id, q[0].data})
          $display("FAIL rnd_rsp c%0d: got id=%b d=%h expected id=%b d=%h",
                   c, bus.RspId, bus.RspData, q[0].id, q[0].data);
        else n_pass++;
        if (bus.RspReady) void'(q.pop_front());
      end
      if (exp_any) begin
        e.id   = exp_id;
        e.data = exp_id ? ref_shift(bus.Req1Sh, int'(bus.Req1Shamt5), bus.Req1ShIn)
                        : ref_shift(bus.Req0Sh, int'(bus.Req0Shamt5), bus.Req0ShIn);
        e.due  = c + ((BYP && ((exp_id ? bus.Req1Shamt5 : bus.Req0Shamt5) == 5'd0)) ? 1 : 2);
        q.push_back(e);
        m_last = exp_id;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ror();
    test_alternate();
    test_backpressure();
    test_reset_inflight();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter PRIO_INIT, default 0, meaning the requester that wins the first tie after reset (0 or 1).
REQ-002 SHALL have port CLK  input  1  meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESETn  input  1  meaning asynchronous active-low reset.
REQ-004 SHALL have ports Req0Valid/Req1Valid  input  1  meaning requester n presents a shift operation.
REQ-005 SHALL have ports Req0Ready/Req1Ready  output  1  meaning requester n's operation is accepted this cycle.
REQ-006 SHALL have ports Req0Sh/Req1Sh  input  2  meaning shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-007 SHALL have ports Req0Shamt5/Req1Shamt5  input  5  meaning shift amount.
REQ-008 SHALL have ports Req0ShIn/Req1ShIn  input  32  meaning operand.
REQ-009 SHALL have ports Sh  output  2, Shamt5  output  5, ShIn  output  32  meaning the drive to the shared combinational barrel shifter.
REQ-010 SHALL have port ShOut  input  32  meaning the shared shifter result.
REQ-011 SHALL have ports RspValid  output  1, RspId  output  1, RspData  output  32  meaning result valid, originating requester, result value.
REQ-012 SHALL have port RspReady  input  1  meaning the consumer accepts the response.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, RESP.
REQ-014 In IDLE, SHALL assert at most one ReqnReady, combinationally, for the granted valid requester; both Ready outputs SHALL be 0 in SHIFT and RESP.
REQ-015 Handshake: a transfer occurs when ReqnValid and ReqnReady are both 1; on transfer, SHALL capture Sh/Shamt5/ShIn/id into operand registers and go to SHIFT.
REQ-016 Arbitration: with one valid requester, grant it; with both valid, grant the requester not served last; the last-served pointer SHALL update only on transfer.
REQ-017 In SHIFT, SHALL drive Sh/Shamt5/ShIn from the operand registers, capture ShOut into RspData at the clock edge, and go to RESP.
REQ-018 In IDLE and RESP, SHALL drive Sh=00, Shamt5=0, ShIn=0.
REQ-019 In RESP, SHALL hold RspValid=1 with RspId/RspData stable until RspReady=1, then return to IDLE.
REQ-020 Latency: transfer at edge N yields RspValid=1 after edge N+2; with RspReady held 1, sustained throughput SHALL be one operation per 3 cycles.
REQ-021 Requester inputs SHALL be ignored when not transferring; a requester dropping Valid before Ready SHALL NOT be served.

Reset
REQ-022 RESETn=0 SHALL immediately force state IDLE, RspValid=0, RspId=0, RspData=0, operand registers to 0, and last-served pointer to the complement of PRIO_INIT.
REQ-023 Reset asserted in SHIFT or RESP SHALL discard the in-flight operation; no response for it SHALL ever appear.
REQ-024 Deassertion of RESETn SHALL take effect at the next CLK rising edge with no spurious Ready or RspValid.

Configuration
REQ-025 Macro SHIFT_ARB_BYPASS_EN: when defined, a transfer with Shamt5=0 SHALL skip SHIFT, load RspData=ShIn directly, and enter RESP at edge N+1 (RspValid after edge N+1).
REQ-026 When SHIFT_ARB_BYPASS_EN is undefined, Shamt5=0 operations SHALL use SHIFT like all others (latency 2).

Verification
REQ-027 Bench (correct barrel shifter on Sh/Shamt5/ShIn/ShOut): Req0 ROR, ShIn=0x80000001, Shamt5=4, RspReady=1 -> RspValid 2 cycles after transfer, RspId=0, RspData=0x18000000.
REQ-028 Req0 and Req1 valid every cycle after reset, PRIO_INIT=0 (Req0 ASR 0x80000000 by 31; Req1 LSL 0x00000001 by 31) -> grants alternate 0,1,0,1; responses 0xFFFFFFFF (Id 0), 0x80000000 (Id 1).
REQ-029 Req1 LSR 0xF0000000 by 4, RspReady=0 for 5 cycles then 1 -> RspValid high and RspData=0x0F000000 stable all 5 cycles; no Ready to either requester until return to IDLE.
REQ-030 RESETn pulsed low while in SHIFT for Req0 LSL 0x12345678 by 8 -> RspValid stays 0, no response for that op; next Req1 operation served normally.
REQ-031 Req0 LSL 0xDEADBEEF by 0 -> RspData=0xDEADBEEF, RspValid after 1 cycle with SHIFT_ARB_BYPASS_EN defined, after 2 cycles without.
